// File: rtl/button_pkg.sv
// Shared types and helpers for the button press generator.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Wide enough to hold the larger of HOLD_CYCLES-1 and GAP_CYCLES-1.
    function automatic int timer_width(input int hold, input int gap);
        return $clog2(max_int(hold, gap)) + 1;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter; zero flags the last cycle of a timed interval.
module cycle_timer #(
    parameter int W = 3
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/button_press_gen.sv
// Turns one-cycle request pulses into clean press waveforms (HOLD high, GAP low),
// queueing requests that arrive while a press is in progress.
module button_press_gen
    import button_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int PEND_W      = 3
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              req,
    output logic              pressed,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              dropped
);

    localparam int              TW        = timer_width(HOLD_CYCLES, GAP_CYCLES);
    localparam logic [TW-1:0]     HOLD_LOAD = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0]     GAP_LOAD  = TW'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = '1;

    state_t        state, state_nx;
    logic          accept;
    logic          tmr_load;
    logic          tmr_dec;
    logic [TW-1:0] tmr_val;
    logic          tmr_zero;
    logic          pend_any;

    assign pend_any = (pending != '0);

    cycle_timer #(.W(TW)) u_timer (
        .Clock    (Clock),
        .Reset    (Reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        tmr_val  = HOLD_LOAD;
        unique case (state)
            IDLE: begin
                if (pend_any) begin
                    state_nx = PRESS;
                    accept   = 1'b1;
                    tmr_load = 1'b1;
                end
            end
            PRESS: begin
                if (!tmr_zero) begin
                    tmr_dec = 1'b1;
                end else begin
                    state_nx = GAP;
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LOAD;
                end
            end
            GAP: begin
                if (!tmr_zero) begin
                    tmr_dec = 1'b1;
                end else if (pend_any) begin
                    state_nx = PRESS;
                    accept   = 1'b1;
                    tmr_load = 1'b1;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= IDLE;
            pressed <= 1'b0;
            busy    <= 1'b0;
            pending <= '0;
            dropped <= 1'b0;
        end else begin
            state   <= state_nx;
            pressed <= (state_nx == PRESS);
            busy    <= (state_nx != IDLE);
            dropped <= req && !accept && (pending == PEND_MAX);
            // Saturating queue: accept only fires with pending > 0, so no underflow.
            if (req && !accept) begin
                if (pending != PEND_MAX) pending <= pending + 1'b1;
            end else if (!req && accept) begin
                pending <= pending - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_button_press_gen.sv
// Randomized and directed checks of button_press_gen against a timeline model
// that tracks press start times instead of FSM states.
module tb_button_press_gen;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       req   = 1'b0;
    logic       pressed_a, busy_a, dropped_a;
    logic       pressed_b, busy_b, dropped_b;
    logic [2:0] pending_a, pending_b;

    always #5 Clock = ~Clock;

    button_press_gen #(.HOLD_CYCLES(4), .GAP_CYCLES(2), .PEND_W(3)) dut_a (
        .Clock   (Clock),
        .Reset   (Reset),
        .req     (req),
        .pressed (pressed_a),
        .busy    (busy_a),
        .pending (pending_a),
        .dropped (dropped_a)
    );

    button_press_gen #(.HOLD_CYCLES(1), .GAP_CYCLES(1), .PEND_W(3)) dut_b (
        .Clock   (Clock),
        .Reset   (Reset),
        .req     (req),
        .pressed (pressed_b),
        .busy    (busy_b),
        .pending (pending_b),
        .dropped (dropped_b)
    );

    // Model state: queue depth, cycle of the most recent press start, drop flag.
    typedef struct packed {
        int   pend;
        int   last_start;
        logic drop;
    } mstate_t;

    localparam int PMAX = 7;

    mstate_t ma, mb;
    int      t = 0;
    int      total = 0;
    int      bad = 0;

    int      nreq, presses_a, presses_b, drops_a, high_a, high_b, peak_a;
    logic    prev_a, prev_b;

    task automatic check(input string tag, input logic [31:0] obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, t);
        end
    endtask

    // A press may start at cycle tc if something is queued and the previous
    // press plus its gap has fully elapsed.
    function automatic mstate_t model_next(input mstate_t m, input logic r, input logic rst,
                                           input int tc, input int h, input int g);
        mstate_t n;
        logic    acc;
        n = m;
        if (rst) begin
            n.pend       = 0;
            n.last_start = -1000;
            n.drop       = 1'b0;
            return n;
        end
        acc = (m.pend > 0) && (tc >= m.last_start + h + g);
        if (acc) n.last_start = tc;
        n.drop = r && !acc && (m.pend == PMAX);
        if (r && !acc && m.pend < PMAX) n.pend = m.pend + 1;
        else if (!r && acc)             n.pend = m.pend - 1;
        return n;
    endfunction

    function automatic int exp_pressed(input mstate_t m, input int tc, input int h);
        return int'((tc >= m.last_start) && (tc < m.last_start + h));
    endfunction

    function automatic int exp_busy(input mstate_t m, input int tc, input int h, input int g);
        return int'(tc < m.last_start + h + g);
    endfunction

    task automatic scenario_begin();
        nreq = 0; presses_a = 0; presses_b = 0; drops_a = 0;
        high_a = 0; high_b = 0; peak_a = 0;
    endtask

    task automatic step(input logic r, input logic rst);
        req   = r;
        Reset = rst;
        @(posedge Clock);
        t++;
        ma = model_next(ma, r, rst, t, 4, 2);
        mb = model_next(mb, r, rst, t, 1, 1);
        if (r && !rst) nreq++;
        @(negedge Clock);
        check("a_pressed", 32'(pressed_a), exp_pressed(ma, t, 4));
        check("a_busy",    32'(busy_a),    exp_busy(ma, t, 4, 2));
        check("a_pending", 32'(pending_a), ma.pend);
        check("a_dropped", 32'(dropped_a), int'(ma.drop));
        check("b_pressed", 32'(pressed_b), exp_pressed(mb, t, 1));
        check("b_busy",    32'(busy_b),    exp_busy(mb, t, 1, 1));
        check("b_pending", 32'(pending_b), mb.pend);
        check("b_dropped", 32'(dropped_b), int'(mb.drop));
        if (pressed_a === 1'b1 && prev_a !== 1'b1) presses_a++;
        if (pressed_b === 1'b1 && prev_b !== 1'b1) presses_b++;
        if (pressed_a === 1'b1) high_a++;
        if (pressed_b === 1'b1) high_b++;
        if (dropped_a === 1'b1) drops_a++;
        if (int'(pending_a) > peak_a) peak_a = int'(pending_a);
        prev_a = pressed_a;
        prev_b = pressed_b;
    endtask

    task automatic run_pattern(input logic [15:0] pat, input int idle);
        for (int i = 0; i < 16; i++) step(pat[i], 1'b0);
        for (int i = 0; i < idle; i++) step(1'b0, 1'b0);
    endtask

    initial begin
        ma = '{pend: 0, last_start: -1000, drop: 1'b0};
        mb = ma;
        prev_a = 1'b0;
        prev_b = 1'b0;
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);

        // Single request: one 4-cycle press.
        scenario_begin();
        run_pattern(16'h0001, 20);
        check("s1_presses_a", 32'(presses_a), 1);
        check("s1_high_a",    32'(high_a), 4);
        check("s1_high_b",    32'(high_b), 1);
        check("s1_drops_a",   32'(drops_a), 0);

        // Three back-to-back requests.
        scenario_begin();
        run_pattern(16'h0007, 30);
        check("s2_presses_a", 32'(presses_a), 3);
        check("s2_presses_b", 32'(presses_b), 3);
        check("s2_peak_a",    32'(peak_a), 2);
        check("s2_high_a",    32'(high_a), 12);

        // One request, then ten more during the press: queue saturates.
        scenario_begin();
        run_pattern(16'h0FFD, 80);
        check("s3_peak_a",    32'(peak_a), 7);
        check("s3_drops_a",   32'(drops_a), 2);
        check("s3_presses_a", 32'(presses_a), 9);
        check("s3_presses_b", 32'(presses_b), 11);

        // Request coincides with the accept at the end of a gap.
        scenario_begin();
        run_pattern(16'h0089, 30);
        check("s4_presses_a", 32'(presses_a), 3);

        // Reset mid-press with three requests queued.
        scenario_begin();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("s5_pending_before", 32'(pending_a), 3);
        step(1'b0, 1'b1);
        check("s5_pressed_after", 32'(pressed_a), 0);
        check("s5_busy_after",    32'(busy_a), 0);
        check("s5_pending_after", 32'(pending_a), 0);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b0);
        check("s5_presses_a", 32'(presses_a), 1);

        // Four consecutive requests; the HOLD=1/GAP=1 instance toggles.
        scenario_begin();
        run_pattern(16'h000F, 30);
        check("s6_presses_b", 32'(presses_b), 4);
        check("s6_high_b",    32'(high_b), 4);
        check("s6_presses_a", 32'(presses_a), 4);

        // Random traffic at varying densities; every request is either pressed or dropped.
        scenario_begin();
        for (int blk = 0; blk < 8; blk++) begin
            int dens;
            dens = (blk % 3 == 0) ? 10 : ((blk % 3 == 1) ? 40 : 90);
            for (int i = 0; i < 40; i++) step(($urandom_range(99) < dens), 1'b0);
        end
        for (int i = 0; i < 80; i++) step(1'b0, 1'b0);
        check("rnd_accounting_a", 32'(presses_a + drops_a), nreq);
        check("rnd_high_a",       32'(high_a), 4 * presses_a);
        check("rnd_idle_pending", 32'(pending_a), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
